// File: rtl/wb_scoreboard_arbiter.sv
// Register-file write port controller: round-robin EXU/LSU writeback arbitration,
// registered write stage and per-register pending-write scoreboard.
module wb_scoreboard_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  input  logic [ADDR_WIDTH-1:0]      issue_rs1,
  input  logic [ADDR_WIDTH-1:0]      issue_rs2,
  output logic                       issue_stall,
  input  logic                       exu_valid,
  output logic                       exu_ready,
  input  logic [ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]   busy,
  output logic                       wb_err
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic                  prio_lsu;
  logic                  hs_exu;
  logic                  hs_lsu;
  logic                  hs_any;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  issue_accept;
  logic [NREG-1:0]       busy_nxt;

  always_comb begin
    exu_ready = !rst && exu_valid && (!lsu_valid || !prio_lsu);
    lsu_ready = !rst && lsu_valid && (!exu_valid || prio_lsu);
  end

  assign hs_exu   = exu_valid && exu_ready;
  assign hs_lsu   = lsu_valid && lsu_ready;
  assign hs_any   = hs_exu || hs_lsu;
  assign win_rd   = hs_lsu ? lsu_rd : exu_rd;
  assign win_data = hs_lsu ? lsu_data : exu_data;

  assign issue_stall  = rst || busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd];
  assign issue_accept = issue_valid && !issue_stall;

  // Clear first so a same-edge set of the same bit takes precedence.
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
    if (issue_accept && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_lsu <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
      wb_err   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (hs_exu)      prio_lsu <= 1'b1;
      else if (hs_lsu) prio_lsu <= 1'b0;
      if (hs_any) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
        rf_wen   <= (win_rd != '0);
        if ((win_rd != '0) && !busy[win_rd]) wb_err <= 1'b1;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Directed bench for wb_scoreboard_arbiter with hand-computed expectations.
module tb_wb_scoreboard_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        exu_valid, exu_ready;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        wb_err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_scoreboard_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    exu_valid = 1; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;

    // Reset with EXU requesting
    step(); step();
    check("rst_exu_ready", exu_ready, 0);
    check("rst_stall", issue_stall, 1);
    check("rst_busy", busy, 0);
    check("rst_rf_wen", rf_wen, 0);
    check("rst_wb_err", wb_err, 0);
    rst = 1'b0;
    settle();
    check("post_rst_exu_ready", exu_ready, 1);
    check("post_rst_lsu_ready", lsu_ready, 0);
    step();
    exu_valid = 0;

    // RAW stall on r5
    issue_valid = 1; issue_rd = 5;
    settle();
    check("raw_issue_nostall", issue_stall, 0);
    step();
    check("raw_busy5", busy, 32'h0000_0020);
    issue_rd = 6; issue_rs1 = 5;
    settle();
    check("raw_stall", issue_stall, 1);
    step();
    check("raw_stalled_no_set", busy, 32'h0000_0020);
    issue_valid = 0;
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEAD_BEEF;
    settle();
    check("raw_exu_ready", exu_ready, 1);
    step();
    exu_valid = 0;
    check("raw_rf_wen", rf_wen, 1);
    check("raw_rf_waddr", rf_waddr, 5);
    check("raw_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("raw_busy_held", busy, 32'h0000_0020);
    check("raw_stall_held", issue_stall, 1);
    step();
    check("raw_rf_wen_low", rf_wen, 0);
    check("raw_busy_clear", busy, 0);
    check("raw_stall_drop", issue_stall, 0);
    check("raw_wb_err", wb_err, 0);
    issue_rs1 = 0; issue_rd = 0;

    // Contention after a fresh reset
    rst = 1; step(); rst = 0;
    issue_valid = 1; issue_rd = 3; step();
    issue_rd = 7; step();
    issue_valid = 0; issue_rd = 0;
    check("cont_busy", busy, 32'h0000_0088);
    exu_valid = 1; exu_rd = 3; exu_data = 32'h33;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
    settle();
    check("cont_exu_first", exu_ready, 1);
    check("cont_lsu_wait", lsu_ready, 0);
    step();
    exu_valid = 0;
    check("cont_waddr0", rf_waddr, 3);
    check("cont_wen0", rf_wen, 1);
    settle();
    check("cont_lsu_next", lsu_ready, 1);
    step();
    lsu_valid = 0;
    check("cont_waddr1", rf_waddr, 7);
    check("cont_wdata1", rf_wdata, 32'h77);
    check("cont_wen1", rf_wen, 1);
    check("cont_busy_mid", busy, 32'h0000_0080);
    step();
    check("cont_busy_done", busy, 0);
    check("cont_wen_low", rf_wen, 0);
    exu_valid = 1; exu_rd = 0; lsu_valid = 1; lsu_rd = 0;
    settle();
    check("ptr_at_exu", exu_ready, 1);
    check("ptr_at_exu_lsu", lsu_ready, 0);
    step();
    check("alt_lsu", lsu_ready, 1);
    check("alt_exu", exu_ready, 0);
    step();
    exu_valid = 0; lsu_valid = 0;

    // x0 handling
    issue_valid = 1; issue_rd = 0;
    settle();
    check("x0_nostall", issue_stall, 0);
    step();
    issue_valid = 0;
    check("x0_busy", busy, 0);
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h123;
    settle();
    check("x0_lsu_ready", lsu_ready, 1);
    step();
    lsu_valid = 0;
    check("x0_rf_wen", rf_wen, 0);
    check("x0_wb_err", wb_err, 0);

    // WAW stall and spurious writeback
    issue_valid = 1; issue_rd = 9; step();
    check("waw_busy9", busy, 32'h0000_0200);
    settle();
    check("waw_stall", issue_stall, 1);
    issue_valid = 0;
    exu_valid = 1; exu_rd = 12; exu_data = 32'hC;
    settle();
    check("err_exu_ready", exu_ready, 1);
    step();
    exu_valid = 0;
    check("err_rf_wen", rf_wen, 1);
    check("err_rf_waddr", rf_waddr, 12);
    check("err_set", wb_err, 1);
    step();
    check("err_busy", busy, 32'h0000_0200);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9;
    step();
    lsu_valid = 0;
    step();
    check("err_busy_clear", busy, 0);
    check("err_sticky", wb_err, 1);
    rst = 1; step(); rst = 0;
    check("err_rst_clear", wb_err, 0);

    // Back-to-back writes of r1..r4
    issue_valid = 1; issue_rd = 0;
    for (int i = 1; i <= 4; i++) begin
      issue_rd = 5'(i);
      step();
    end
    issue_valid = 0; issue_rd = 0;
    check("b2b_busy", busy, 32'h0000_001E);
    exu_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      exu_rd = 5'(i); exu_data = 32'h100 + 32'(i);
      step();
      check($sformatf("b2b_wen%0d", i), rf_wen, 1);
      check($sformatf("b2b_waddr%0d", i), rf_waddr, 64'(i));
      check($sformatf("b2b_wdata%0d", i), rf_wdata, 64'(32'h100 + 32'(i)));
      check($sformatf("b2b_busy%0d", i), busy, 64'(32'h1E & ~((32'h2 << (i - 1)) - 32'h2)));
    end
    exu_valid = 0;
    step();
    check("b2b_wen_low", rf_wen, 0);
    check("b2b_busy_done", busy, 0);
    check("b2b_wb_err", wb_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard_arbiter.md
Name: wb_scoreboard_arbiter

Overview:
- Controls the write port of the general-purpose register file and tracks pending writes.
- Arbitrates two writeback requesters, the execute unit (EXU) and the load/store unit (LSU), onto the single register-file write port using round-robin.
- Registers the winning write, one cycle per write.
- Keeps a per-register busy scoreboard; the issue stage uses it to stall on RAW/WAW hazards.

Parameters:
- ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue stage presents an instruction.
- issue_rd  in  ADDR_WIDTH  destination register of issuing instruction.
- issue_rs1  in  ADDR_WIDTH  source register 1.
- issue_rs2  in  ADDR_WIDTH  source register 2.
- issue_stall  out  1  issue must hold; combinational.
- exu_valid  in  1  EXU writeback request.
- exu_ready  out  1  EXU request granted this cycle; combinational.
- exu_rd  in  ADDR_WIDTH  EXU destination.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU writeback request.
- lsu_ready  out  1  LSU request granted this cycle; combinational.
- lsu_rd  in  ADDR_WIDTH  LSU destination.
- lsu_data  in  DATA_WIDTH  LSU load data.
- rf_wen  out  1  register-file write enable; registered.
- rf_waddr  out  ADDR_WIDTH  register-file write address; registered.
- rf_wdata  out  DATA_WIDTH  register-file write data; registered.
- busy  out  2**ADDR_WIDTH  scoreboard vector; bit r = write to r pending.
- wb_err  out  1  sticky flag: writeback to a non-busy register other than x0.

Behaviour:
- Reset (rst=1 at posedge):
  - busy=0, rf_wen=0, rf_waddr=0, rf_wdata=0, wb_err=0.
  - Priority pointer = EXU.
  - While rst=1: exu_ready=lsu_ready=0 and issue_stall=1.
  - Reset mid-operation drops all in-flight grants and pending marks.
- Issue stall: issue_stall = busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]. busy[0] is constant 0.
- Issue accept: issue_valid & !issue_stall at posedge sets busy[issue_rd]. issue_rd=0 marks nothing.
- Arbitration (combinational, same cycle):
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the pointer's requester gets ready=1.
  - Neither valid: both ready=0.
  - A handshake is valid&ready.
- Pointer update: after any handshake, the pointer moves to the requester NOT granted. With no handshake the pointer holds.
- Write register:
  - On a handshake, at the next posedge rf_waddr/rf_wdata latch the granted rd/data, and rf_wen <= (rd != 0).
  - With no handshake, rf_wen <= 0 and rf_waddr/rf_wdata hold.
  - Latency: handshake in cycle N -> rf_wen high in cycle N+1 -> register file written at the end of cycle N+1.
- Busy clear:
  - At the posedge where rf_wen=1, busy[rf_waddr] clears, on the same edge the register file captures the data. Readers in the following cycle see the new value with busy=0.
  - No bypass is provided.
- Simultaneous set and clear of the same bit on one edge: set wins. This is unreachable in normal flow, because issue stalls while busy[rd]=1.
- Error: a handshake with rd!=0 and busy[rd]=0 sets wb_err, which clears only on rst. The write is still performed.
- Throughput: one write per cycle sustained. Two continuously valid requesters alternate EXU, LSU, EXU, ...
- Requesters must hold valid/rd/data stable until ready. The block does not check this.

Test Plan:
- Reset: assert rst 2 cycles with exu_valid=1 -> exu_ready=0, busy=0, rf_wen=0, wb_err=0. After release with exu_valid=1, exu_ready=1 in the first cycle.
- RAW stall: issue rd=5 accepted -> busy[5]=1. Next issue rs1=5 -> issue_stall=1. EXU writes rd=5 data=0xDEADBEEF -> rf_wen=1, rf_waddr=5 one cycle later. issue_stall drops the cycle after rf_wen.
- Contention: issue rd=3 and rd=7, then hold exu_valid(rd=3) and lsu_valid(rd=7) together after reset -> EXU granted first, LSU next cycle. rf_waddr sequence 3, 7 on consecutive cycles. Pointer ends at EXU.
- x0: issue rd=0 -> busy unchanged, no stall. LSU writeback rd=0 -> lsu_ready=1, rf_wen stays 0, wb_err stays 0.
- WAW/error: issue rd=9 -> an issue with rd=9 stalls. Write to rd=12 while busy[12]=0 -> write performed, wb_err=1 and stays 1 until rst.
- Back-to-back: issue rd=1..4, then EXU valid for 4 consecutive cycles -> rf_wen high 4 consecutive cycles, busy[4:1] clear one per cycle, in order.
